// File: rtl/piano_pkg.sv
// Shared constants for the piano voice path.
//   NUM_KEYS   : number of piano keys (C4..E5)
//   DELAY_W    : width of a tone half-period compare value
//   key_idx_t  : 4-bit key index
//   note_delay : half-period minus 1 at 50 MHz for each key
package piano_pkg;
  localparam int NUM_KEYS = 10;
  localparam int DELAY_W  = 19;

  typedef logic [3:0] key_idx_t;

  function automatic logic [DELAY_W-1:0] note_delay(input key_idx_t k);
    case (k)
      4'd0:    note_delay = 19'd95554;  // C4
      4'd1:    note_delay = 19'd85131;  // D4
      4'd2:    note_delay = 19'd75841;  // E4
      4'd3:    note_delay = 19'd71585;  // F4
      4'd4:    note_delay = 19'd63774;  // G4
      4'd5:    note_delay = 19'd56817;  // A4
      4'd6:    note_delay = 19'd50618;  // B4
      4'd7:    note_delay = 19'd47777;  // C5
      4'd8:    note_delay = 19'd42564;  // D5
      4'd9:    note_delay = 19'd37921;  // E5
      default: note_delay = '0;         // no such key
    endcase
  endfunction
endpackage

// File: rtl/voice_pick.sv
// Combinational slot selection for one request key.
//   en_i   : per-slot sounding flags
//   vkey_i : per-slot owning key index
//   age_i  : per-slot age counters
//   req_i  : requested key index
//   hit_o/hit_vld_o   : lowest slot already sounding req_i
//   free_o/free_vld_o : lowest slot not sounding
//   old_o/old_vld_o   : enabled slot with the largest age, ties to lowest index
module voice_pick #(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W      = 4,
  localparam int VW        = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic [NUM_VOICES-1:0]            en_i,
  input  logic [NUM_VOICES-1:0][3:0]       vkey_i,
  input  logic [NUM_VOICES-1:0][AGE_W-1:0] age_i,
  input  logic [3:0]                       req_i,
  output logic [VW-1:0]                    hit_o,
  output logic                             hit_vld_o,
  output logic [VW-1:0]                    free_o,
  output logic                             free_vld_o,
  output logic [VW-1:0]                    old_o,
  output logic                             old_vld_o
);
  import piano_pkg::*;

  logic [AGE_W-1:0] best;

  always_comb begin
    hit_o      = '0;
    hit_vld_o  = 1'b0;
    free_o     = '0;
    free_vld_o = 1'b0;
    old_o      = '0;
    old_vld_o  = 1'b0;
    best       = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (en_i[v] && vkey_i[v] == req_i && !hit_vld_o) begin
        hit_vld_o = 1'b1;
        hit_o     = VW'(v);
      end
      if (!en_i[v] && !free_vld_o) begin
        free_vld_o = 1'b1;
        free_o     = VW'(v);
      end
      // strict '>' keeps the lowest index on ties
      if (en_i[v] && (!old_vld_o || age_i[v] > best)) begin
        old_vld_o = 1'b1;
        old_o     = VW'(v);
        best      = age_i[v];
      end
    end
  end
endmodule

// File: rtl/voice_allocator.sv
// Polyphonic note scheduler: turns key levels into press/release events and
// assigns presses to tone-generator slots, one event per cycle.
//   CLOCK_50    : system clock
//   resetn      : async active-low reset
//   key_in      : synchronised key levels, bit k = key k held
//   voice_en    : slot v sounding
//   voice_delay : slot v half-period compare, bits [v*DELAY_W +: DELAY_W]
//   voice_key   : slot v owning key, 4 bits per slot
//   busy        : events still pending
// Build option: VOICE_STEAL_EN -- when defined, a press with no free slot
// steals the oldest slot; otherwise the press is dropped.
module voice_allocator #(
  parameter int NUM_KEYS   = piano_pkg::NUM_KEYS,
  parameter int NUM_VOICES = 4,
  parameter int DELAY_W    = piano_pkg::DELAY_W,
  parameter int AGE_W      = 4
) (
  input  logic                          CLOCK_50,
  input  logic                          resetn,
  input  logic [NUM_KEYS-1:0]           key_in,
  output logic [NUM_VOICES-1:0]         voice_en,
  output logic [NUM_VOICES*DELAY_W-1:0] voice_delay,
  output logic [NUM_VOICES*4-1:0]       voice_key,
  output logic                          busy
);
  import piano_pkg::*;

  localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
`ifdef VOICE_STEAL_EN
  localparam bit STEAL_EN = 1'b1;
`else
  localparam bit STEAL_EN = 1'b0;
`endif

  logic [NUM_KEYS-1:0] key_prev_q, pend_press_q, pend_rel_q;
  logic [NUM_KEYS-1:0] pend_press_d, pend_rel_d;
  logic [NUM_KEYS-1:0] rise, fall, sel;
  logic [NUM_VOICES-1:0] en_q, en_d;
  logic [NUM_VOICES-1:0][3:0] key_q, key_d;
  logic [NUM_VOICES-1:0][DELAY_W-1:0] delay_q, delay_d;
  logic [NUM_VOICES-1:0][AGE_W-1:0] age_q, age_d;

  logic     svc_rel, svc_prs, take;
  key_idx_t svc_key;
  logic [VW-1:0] slot, hit_s, free_s, old_s;
  logic          hit_v, free_v, old_v;

  assign rise = key_in & ~key_prev_q;
  assign fall = ~key_in & key_prev_q;

  // Pick one event from registered pending bits; a press whose key falls
  // this cycle is already cancelled and must not be serviced.
  always_comb begin
    svc_rel = 1'b0;
    svc_prs = 1'b0;
    svc_key = '0;
    sel     = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (!svc_rel && pend_rel_q[k]) begin
        svc_rel = 1'b1;
        svc_key = 4'(k);
        sel[k]  = 1'b1;
      end
    end
    if (!svc_rel) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (!svc_prs && pend_press_q[k] && !fall[k]) begin
          svc_prs = 1'b1;
          svc_key = 4'(k);
          sel[k]  = 1'b1;
        end
      end
    end
  end

  voice_pick #(.NUM_VOICES(NUM_VOICES), .AGE_W(AGE_W)) u_pick (
    .en_i      (en_q),
    .vkey_i    (key_q),
    .age_i     (age_q),
    .req_i     (svc_key),
    .hit_o     (hit_s),
    .hit_vld_o (hit_v),
    .free_o    (free_s),
    .free_vld_o(free_v),
    .old_o     (old_s),
    .old_vld_o (old_v)
  );

  always_comb begin
    en_d         = en_q;
    key_d        = key_q;
    delay_d      = delay_q;
    age_d        = age_q;
    take         = 1'b0;
    slot         = '0;
    pend_rel_d   = (pend_rel_q | fall) & ~(svc_rel ? sel : '0);
    pend_press_d = (pend_press_q | rise) & ~fall & ~(svc_prs ? sel : '0);

    if (svc_rel) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (en_q[v] && key_q[v] == svc_key) begin
          en_d[v]  = 1'b0;
          age_d[v] = '0;
        end
      end
    end else if (svc_prs) begin
      if (hit_v) begin
        take = 1'b1;
        slot = hit_s;
      end else if (free_v) begin
        take = 1'b1;
        slot = free_s;
      end else if (STEAL_EN && old_v) begin
        take = 1'b1;
        slot = old_s;
      end
      if (take) begin
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (VW'(v) == slot) begin
            en_d[v]    = 1'b1;
            key_d[v]   = svc_key;
            delay_d[v] = DELAY_W'(note_delay(svc_key));
            age_d[v]   = '0;
          end else if (en_q[v] && age_q[v] != {AGE_W{1'b1}}) begin
            age_d[v] = age_q[v] + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      key_prev_q   <= '0;
      pend_press_q <= '0;
      pend_rel_q   <= '0;
      en_q         <= '0;
      key_q        <= '0;
      delay_q      <= '0;
      age_q        <= '0;
    end else begin
      key_prev_q   <= key_in;
      pend_press_q <= pend_press_d;
      pend_rel_q   <= pend_rel_d;
      en_q         <= en_d;
      key_q        <= key_d;
      delay_q      <= delay_d;
      age_q        <= age_d;
    end
  end

  assign voice_en    = en_q;
  assign voice_key   = key_q;
  assign voice_delay = delay_q;
  assign busy        = |pend_press_q | |pend_rel_q;
endmodule

// File: tb/tb_voice_allocator.sv
module tb_voice_allocator;
  logic        clk = 1'b0;
  logic        rstn;
  logic [9:0]  key_in;
  logic [3:0]  ven;
  logic [75:0] vdly;
  logic [15:0] vkey;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  voice_allocator dut (
    .CLOCK_50   (clk),
    .resetn     (rstn),
    .key_in     (key_in),
    .voice_en   (ven),
    .voice_delay(vdly),
    .voice_key  (vkey),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rstn   = 1'b0;
    key_in = '0;
    #12;
    chk("rst_en",    32'(ven),  32'h0);
    chk("rst_key",   32'(vkey), 32'h0);
    chk("rst_dly0",  32'(vdly[0 +: 19]), 32'd0);
    chk("rst_busy",  32'(busy), 32'h0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // single press / release of key 0
    key_in = 10'h001;
    step(1);
    chk("p0_cap_en",   32'(ven),  32'h0);
    chk("p0_cap_busy", 32'(busy), 32'h1);
    step(1);
    chk("p0_en",   32'(ven),  32'h1);
    chk("p0_dly",  32'(vdly[0 +: 19]), 32'd95554);
    chk("p0_key",  32'(vkey[3:0]), 32'd0);
    chk("p0_busy", 32'(busy), 32'h0);
    key_in = 10'h000;
    step(2);
    chk("r0_en", 32'(ven), 32'h0);
    chk("r0_dly_hold", 32'(vdly[0 +: 19]), 32'd95554);

    // keys 0,2,5 together
    key_in = 10'b00_0010_0101;
    step(1);
    chk("m_cap_busy", 32'(busy), 32'h1);
    step(1);
    chk("m1_en", 32'(ven), 32'h1);
    chk("m1_busy", 32'(busy), 32'h1);
    step(1);
    chk("m2_en", 32'(ven), 32'h3);
    chk("m2_key1", 32'(vkey[7:4]), 32'd2);
    chk("m2_busy", 32'(busy), 32'h1);
    step(1);
    chk("m3_en", 32'(ven), 32'h7);
    chk("m3_key2", 32'(vkey[11:8]), 32'd5);
    chk("m3_dly2", 32'(vdly[38 +: 19]), 32'd56817);
    chk("m3_busy", 32'(busy), 32'h0);
    key_in = 10'h000;
    step(4);
    chk("m_rel_en", 32'(ven), 32'h0);

    // all slots full, then key 9
    key_in = 10'h00F;
    step(5);
    chk("f_en",  32'(ven),  32'hF);
    chk("f_key", 32'(vkey), 32'h3210);
    chk("f_busy", 32'(busy), 32'h0);
    key_in = 10'h20F;
    step(1);
    chk("k9_cap_busy", 32'(busy), 32'h1);
    step(1);
    chk("k9_busy", 32'(busy), 32'h0);
    chk("k9_en", 32'(ven), 32'hF);
`ifdef VOICE_STEAL_EN
    chk("k9_key",  32'(vkey), 32'h3219);
    chk("k9_dly0", 32'(vdly[0 +: 19]), 32'd37921);
    key_in = 10'h20E;              // release stolen key 0
    step(2);
    chk("k0_rel_en",  32'(ven),  32'hF);
    chk("k0_rel_key", 32'(vkey), 32'h3219);
`else
    chk("k9_key",  32'(vkey), 32'h3210);
    chk("k9_dly0", 32'(vdly[0 +: 19]), 32'd95554);
    key_in = 10'h00F;              // release dropped key 9
    step(2);
    chk("k9_rel_en",  32'(ven),  32'hF);
    chk("k9_rel_key", 32'(vkey), 32'h3210);
`endif
    key_in = 10'h000;
    step(6);
    chk("f_rel_en", 32'(ven), 32'h0);
    chk("f_rel_busy", 32'(busy), 32'h0);

    // key 4 glitch while releases pending
    key_in = 10'h007;
    step(4);
    chk("g_en", 32'(ven), 32'h7);
    key_in = 10'h010;
    step(1);
    chk("g_cap_en", 32'(ven), 32'h7);
    chk("g_cap_busy", 32'(busy), 32'h1);
    key_in = 10'h000;
    step(1);
    chk("g1_en", 32'(ven), 32'h6);
    step(1);
    chk("g2_en", 32'(ven), 32'h4);
    step(1);
    chk("g3_en", 32'(ven), 32'h0);
    step(1);
    chk("g4_en", 32'(ven), 32'h0);
    chk("g4_busy", 32'(busy), 32'h0);

    // async reset mid-operation with key 1 held
    key_in = 10'h002;
    step(2);
    chk("x_en", 32'(ven), 32'h1);
    chk("x_key", 32'(vkey[3:0]), 32'd1);
    #3;
    rstn = 1'b0;
    #1;
    chk("x_rst_en",  32'(ven),  32'h0);
    chk("x_rst_key", 32'(vkey), 32'h0);
    chk("x_rst_dly", 32'(vdly[0 +: 19]), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    step(1);
    chk("x_cap_en", 32'(ven), 32'h0);
    chk("x_cap_busy", 32'(busy), 32'h1);
    step(1);
    chk("x_re_en",  32'(ven), 32'h1);
    chk("x_re_key", 32'(vkey[3:0]), 32'd1);
    chk("x_re_dly", 32'(vdly[0 +: 19]), 32'd85131);
    key_in = 10'h000;
    step(3);
    chk("x_end_en", 32'(ven), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Polyphonic note scheduler for the square-wave tone generators.
- Turns the 10 piano key levels into press and release events, assigns each press to one of NUM_VOICES tone-generator slots, and drives each slot's half-period compare value and enable.
- Sits between the switch/key input and the per-voice tone counters. Its outputs feed the tone counters' delay compare value directly.

Parameters:
- NUM_KEYS, 10, number of key inputs (C4..E5).
- NUM_VOICES, 4, number of tone-generator slots managed.
- DELAY_W, 19, width of each half-period compare value.
- AGE_W, 4, width of each voice age counter (saturating).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- resetn  in  1  asynchronous active-low reset.
- key_in  in  NUM_KEYS  key levels, already synchronised to CLOCK_50; bit k = key k held.
- voice_en  out  NUM_VOICES  slot v is sounding.
- voice_delay  out  NUM_VOICES*DELAY_W  slot v half-period compare value; slot v occupies bits [v*DELAY_W +: DELAY_W].
- voice_key  out  NUM_VOICES*4  key index owning slot v, 4 bits per slot.
- busy  out  1  unprocessed events pending.

Behaviour:
- Reset (async, resetn=0): voice_en=0, voice_delay=0, voice_key=0, busy=0, all ages=0, key_prev=0, pend_press=0, pend_rel=0.
- Keys already held when reset is released are seen as presses, because key_prev resets to 0.
- Edge capture, every cycle:
  - rise = key_in & ~key_prev; fall = ~key_in & key_prev; key_prev <= key_in.
  - pend_press |= rise; pend_rel |= fall.
  - A fall on key k clears pend_press[k] in the same cycle. A press that is released before it is serviced never sounds.
- busy = |pend_press | |pend_rel.
- Service: at most one event per cycle.
  - Releases take priority over presses.
  - Within each class, the lowest key index goes first.
  - The serviced pending bit is cleared in the same cycle it is serviced.
- Release of key k:
  - Any slot with voice_en=1 and voice_key=k gets voice_en<=0 and age<=0. voice_delay holds its last value.
  - If no slot holds k (the voice was stolen, or the press was dropped), nothing happens.
- Press of key k:
  - If a slot already sounds k, that slot's age resets to 0 and no new slot is taken.
  - Otherwise the lowest-index slot with voice_en=0 is used.
  - If every slot is busy, the oldest slot (maximum age) is stolen; ties go to the lowest index.
  - The chosen slot is loaded with voice_en<=1, voice_key<=k, voice_delay<=NOTE_DELAY[k], age<=0.
  - All other enabled slots increment age, saturating at 2^AGE_W-1.
- Latency:
  - A single isolated key_in edge at cycle t is captured at edge t+1.
  - Outputs update at edge t+2.
  - N simultaneous edges finish by edge t+1+N.
- Key indices >= NUM_KEYS do not exist; NOTE_DELAY entries beyond NUM_KEYS are unused.
- A pending event and a new edge on the same key in the same cycle: the capture happens first, so the event resolves against the updated pending bits.
- Outputs are fully registered; nothing passes combinationally from key_in to an output.

Optional Feature:
- Macro: VOICE_STEAL_EN.
- Defined: oldest-voice stealing as described above.
- Undefined: when all slots are busy, the press is dropped. Its pend_press bit is cleared, no slot changes, and no age changes. The later release of that key finds no slot and is ignored.

Decomposition:
- piano_pkg holds:
  - NUM_KEYS and DELAY_W constants.
  - A 4-bit key-index typedef.
  - The NOTE_DELAY table, half-period minus 1 at 50 MHz: 95554, 85131, 75841, 71585, 63774, 56817, 50618, 47777, 42564, 37921 (C4..E5).
- Sub-module voice_pick (combinational), output registered by voice_allocator:
  - Inputs: voice_en, voice_key, ages, request key.
  - Outputs: hit slot, free slot, oldest slot, and their valid flags.

Test Plan:
- Reset, then press key 0 only: voice_en=0001, voice_delay[0]=95554, voice_key[0]=0 two cycles after the edge; release it: voice_en=0000 two cycles later.
- Keys 0, 2, 5 rise in the same cycle: slots 0/1/2 receive keys 0/2/5 on three consecutive cycles; busy is high for 3 cycles.
- Keys 0..3 held, then press key 9 with VOICE_STEAL_EN defined: slot 0 (key 0, oldest) reloads with voice_key=9, voice_delay=37921; a later release of key 0 changes nothing.
- Same stimulus as the previous scenario with VOICE_STEAL_EN undefined: no slot changes, busy drops after 1 cycle, and the release of key 9 is ignored.
- Key 4 rises and falls on consecutive cycles while 3 releases are pending: key 4 never sounds and voice_en does not change for it.
- Hold key 1, assert resetn=0 mid-operation, then deassert: outputs clear immediately; key 1 is reallocated to slot 0 two cycles after resetn rises.
